// File: rtl/jstk_spi_reader_if.sv
// rtl/jstk_spi_reader_if.sv - SPI bus bundle between the joystick reader and the Pmod JSTK
//   sclk : SPI clock, mode 0, idles low (master -> slave)
//   mosi : data to the JSTK, MSB first (master -> slave)
//   ss   : slave select, active low (master -> slave)
//   miso : data from the JSTK (slave -> master)
interface jstk_spi_reader_if;
  logic sclk;
  logic mosi;
  logic miso;
  logic ss;

  modport master (output sclk, output mosi, output ss, input miso);
  modport slave  (input sclk, input mosi, input ss, output miso);
endinterface

// File: rtl/jstk_spi_reader.sv
// rtl/jstk_spi_reader.sv - SPI master polling the Pmod JSTK, publishes x/y/buttons atomically
//   clk        : system clock
//   rst        : asynchronous active-low reset
//   led_cmd    : JSTK LED bits, latched at transaction start
//   spi        : SPI bus (master modport: sclk, mosi, ss out; miso in)
//   x_val      : joystick X, 0..1023 (drive stage)
//   y_val      : joystick Y, 0..1023 (steering stage), centre 512 out of reset
//   btn        : {btn2, btn1, trigger}
//   data_valid : one-cycle pulse when x_val/y_val/btn update
//   busy       : high while ss is low
module jstk_spi_reader #(
  parameter int SCLK_DIV     = 50,
  parameter int SS_SETUP_CYC = 1500,
  parameter int BYTE_GAP_CYC = 1000,
  parameter int POLL_CYC     = 1_000_000
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [1:0]             led_cmd,
  jstk_spi_reader_if.master      spi,
  output logic [9:0]             x_val,
  output logic [9:0]             y_val,
  output logic [2:0]             btn,
  output logic                   data_valid,
  output logic                   busy
);

  localparam int CNT_MAX_A = (SS_SETUP_CYC > BYTE_GAP_CYC) ? SS_SETUP_CYC : BYTE_GAP_CYC;
  localparam int CNT_MAX   = (CNT_MAX_A > 2 * SCLK_DIV) ? CNT_MAX_A : 2 * SCLK_DIV;
  localparam int CW        = $clog2(CNT_MAX + 1);
  localparam int TW        = $clog2(POLL_CYC + 1);

  localparam logic [CW-1:0] SETUP_LAST = CW'(SS_SETUP_CYC - 1);
  localparam logic [CW-1:0] GAP_LAST   = CW'(BYTE_GAP_CYC - 1);
  localparam logic [CW-1:0] LOW_LAST   = CW'(SCLK_DIV - 1);
  localparam logic [CW-1:0] BIT_LAST   = CW'(2 * SCLK_DIV - 1);
  localparam logic [TW-1:0] POLL_LAST  = TW'(POLL_CYC - 1);

  typedef enum logic [2:0] {IDLE, SETUP, SHIFT, GAP, DONE} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [2:0]      bit_q, bit_d;
  logic [2:0]      byte_q, byte_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic            pend_q, pend_d;
  logic [1:0]      led_q, led_d;
  logic [7:0]      rx_sr_q, rx_sr_d;
  // Received bytes are staged here and only copied to the outputs in DONE,
  // so an aborted transaction never leaks partial data.
  logic [7:0]      x_lo_q, x_lo_d;
  logic [1:0]      x_hi_q, x_hi_d;
  logic [7:0]      y_lo_q, y_lo_d;
  logic [1:0]      y_hi_q, y_hi_d;
  logic            sclk_q, sclk_d;
  logic            mosi_q, mosi_d;
  logic            ss_q, ss_d;
  logic            busy_q, busy_d;
  logic            dv_q, dv_d;
  logic [9:0]      x_q, x_d;
  logic [9:0]      y_q, y_d;
  logic [2:0]      btn_q, btn_d;
  logic            tick;
  logic            start;
  logic [7:0]      tx_byte;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      byte_q  <= '0;
      timer_q <= '0;
      pend_q  <= 1'b0;
      led_q   <= '0;
      rx_sr_q <= '0;
      x_lo_q  <= '0;
      x_hi_q  <= '0;
      y_lo_q  <= '0;
      y_hi_q  <= '0;
      sclk_q  <= 1'b0;
      mosi_q  <= 1'b0;
      ss_q    <= 1'b1;
      busy_q  <= 1'b0;
      dv_q    <= 1'b0;
      x_q     <= 10'd512;
      y_q     <= 10'd512;
      btn_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      byte_q  <= byte_d;
      timer_q <= timer_d;
      pend_q  <= pend_d;
      led_q   <= led_d;
      rx_sr_q <= rx_sr_d;
      x_lo_q  <= x_lo_d;
      x_hi_q  <= x_hi_d;
      y_lo_q  <= y_lo_d;
      y_hi_q  <= y_hi_d;
      sclk_q  <= sclk_d;
      mosi_q  <= mosi_d;
      ss_q    <= ss_d;
      busy_q  <= busy_d;
      dv_q    <= dv_d;
      x_q     <= x_d;
      y_q     <= y_d;
      btn_q   <= btn_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    byte_d  = byte_q;
    led_d   = led_q;
    rx_sr_d = rx_sr_q;
    x_lo_d  = x_lo_q;
    x_hi_d  = x_hi_q;
    y_lo_d  = y_lo_q;
    y_hi_d  = y_hi_q;
    sclk_d  = sclk_q;
    mosi_d  = mosi_q;
    ss_d    = ss_q;
    busy_d  = busy_q;
    dv_d    = 1'b0;
    x_d     = x_q;
    y_d     = y_q;
    btn_d   = btn_q;

    // Free-running poll timer; a tick that lands mid-transaction is remembered
    // in pend_q and consumed on return to IDLE.
    tick    = (timer_q == POLL_LAST);
    timer_d = tick ? '0 : timer_q + TW'(1);
    start   = tick | pend_q;
    pend_d  = start & (state_q != IDLE);

    tx_byte = (byte_q == 3'd0) ? {6'b100000, led_q} : 8'h00;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = SETUP;
          ss_d    = 1'b0;
          busy_d  = 1'b1;
          led_d   = led_cmd;
          cnt_d   = '0;
          byte_d  = '0;
        end
      end
      SETUP: begin
        if (cnt_q == SETUP_LAST) begin
          state_d = SHIFT;
          cnt_d   = '0;
          bit_d   = '0;
          mosi_d  = tx_byte[7];
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      SHIFT: begin
        if (cnt_q == LOW_LAST) begin
          // Rising SCLK edge: sample miso as sclk goes high.
          sclk_d  = 1'b1;
          rx_sr_d = {rx_sr_q[6:0], spi.miso};
          cnt_d   = cnt_q + CW'(1);
        end else if (cnt_q == BIT_LAST) begin
          sclk_d = 1'b0;
          cnt_d  = '0;
          if (bit_q == 3'd7) begin
            case (byte_q)
              3'd0:    x_lo_d = rx_sr_q;
              3'd1:    x_hi_d = rx_sr_q[1:0];
              3'd2:    y_lo_d = rx_sr_q;
              3'd3:    y_hi_d = rx_sr_q[1:0];
              default: ;
            endcase
            if (byte_q == 3'd4) begin
              state_d = DONE;
              ss_d    = 1'b1;
              busy_d  = 1'b0;
              mosi_d  = 1'b0;
              dv_d    = 1'b1;
              x_d     = {x_hi_q, x_lo_q};
              y_d     = {y_hi_q, y_lo_q};
              btn_d   = rx_sr_q[2:0];
            end else begin
              state_d = GAP;
              byte_d  = byte_q + 3'd1;
            end
          end else begin
            bit_d  = bit_q + 3'd1;
            mosi_d = tx_byte[3'd6 - bit_q];
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      GAP: begin
        if (cnt_q == GAP_LAST) begin
          state_d = SHIFT;
          cnt_d   = '0;
          bit_d   = '0;
          mosi_d  = tx_byte[7];
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign spi.sclk   = sclk_q;
  assign spi.mosi   = mosi_q;
  assign spi.ss     = ss_q;
  assign x_val      = x_q;
  assign y_val      = y_q;
  assign btn        = btn_q;
  assign data_valid = dv_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_jstk_spi_reader.sv
// tb/tb_jstk_spi_reader.sv - self-checking bench for jstk_spi_reader with a JSTK slave model
module tb_jstk_spi_reader;

  localparam int SCLK_DIV     = 2;
  localparam int SS_SETUP_CYC = 4;
  localparam int BYTE_GAP_CYC = 3;
  localparam int POLL_CYC     = 400;
  localparam int SS_LOW       = SS_SETUP_CYC + 80 * SCLK_DIV + 4 * BYTE_GAP_CYC;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] led_cmd;
  logic [9:0] x_val, y_val;
  logic [2:0] btn;
  logic       data_valid, busy;

  jstk_spi_reader_if spi ();

  jstk_spi_reader #(
    .SCLK_DIV(SCLK_DIV), .SS_SETUP_CYC(SS_SETUP_CYC),
    .BYTE_GAP_CYC(BYTE_GAP_CYC), .POLL_CYC(POLL_CYC)
  ) dut (
    .clk(clk), .rst(rst), .led_cmd(led_cmd), .spi(spi),
    .x_val(x_val), .y_val(y_val), .btn(btn),
    .data_valid(data_valid), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [39:0] rx;
    logic [1:0]  led;
    logic        flip;
    logic [7:0]  mosi0;
    logic [9:0]  x;
    logic [9:0]  y;
    logic [2:0]  btn;
  } vec_t;

  typedef struct packed {
    logic [9:0] x;
    logic [9:0] y;
    logic [2:0] btn;
  } exp_t;

  vec_t       vecs [9];
  exp_t       exp_q [$];
  logic [7:0] mosi_q [$];
  int         n_checks = 0;
  int         n_fail   = 0;
  int         cyc      = 0;
  int         last_fall = 0;
  int         dv_count = 0;
  logic       prev_dv  = 1'b0;

  // Slave model: byte stream in slv_tx, MSB of byte 0 at bit 39.
  logic [39:0] slv_tx = '0;
  int          slv_byte = 0;
  int          slv_bit  = 0;
  logic [7:0]  mosi_sr  = '0;

  initial spi.miso = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge spi.ss) begin
    slv_byte = 0;
    slv_bit  = 0;
    spi.miso = slv_tx[39];
  end

  always @(posedge spi.sclk) begin
    if (spi.ss === 1'b0) begin
      mosi_sr = {mosi_sr[6:0], spi.mosi};
      slv_bit++;
      if (slv_bit == 8) begin
        mosi_q.push_back(mosi_sr);
        slv_bit = 0;
        slv_byte++;
      end
    end
  end

  always @(negedge spi.sclk) begin
    if (spi.ss === 1'b0)
      spi.miso = (slv_byte < 5) ? slv_tx[39 - 8 * slv_byte - slv_bit] : 1'b0;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Scoreboard consumer: every data_valid pulse pops one expectation.
  always @(negedge clk) begin
    if (data_valid === 1'b1) begin
      exp_t e;
      dv_count++;
      check("dv_single_pulse", 32'(prev_dv), 32'd0);
      if (exp_q.size() == 0) begin
        check("dv_unexpected", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("x_val", 32'(x_val), 32'(e.x));
        check("y_val", 32'(y_val), 32'(e.y));
        check("btn", 32'(btn), 32'(e.btn));
      end
    end
    prev_dv = data_valid;
  end

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ss"}, 32'(spi.ss), 32'd1);
    check({tag, "_sclk"}, 32'(spi.sclk), 32'd0);
    check({tag, "_mosi"}, 32'(spi.mosi), 32'd0);
    check({tag, "_x"}, 32'(x_val), 32'd512);
    check({tag, "_y"}, 32'(y_val), 32'd512);
    check({tag, "_btn"}, 32'(btn), 32'd0);
    check({tag, "_dv"}, 32'(data_valid), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
  endtask

  task automatic wait_ss_fall();
    int n = 0;
    while (spi.ss !== 1'b0 && n < 2 * POLL_CYC) begin
      @(posedge clk);
      #1;
      n++;
    end
  endtask

  task automatic run_txn(input int i, input int ref_cyc);
    int n, bad;
    slv_tx  = vecs[i].rx;
    led_cmd = vecs[i].led;
    exp_q.push_back('{vecs[i].x, vecs[i].y, vecs[i].btn});
    mosi_q.delete();
    wait_ss_fall();
    check("ss_fall_cycle", 32'(cyc), 32'(ref_cyc + POLL_CYC));
    last_fall = cyc;
    n = 0;
    bad = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
      if (busy !== ~spi.ss) bad++;
      if (vecs[i].flip && n == 60) led_cmd = ~vecs[i].led;
    end while (spi.ss === 1'b0 && n < 4 * SS_LOW);
    check("ss_low_cycles", 32'(n), 32'(SS_LOW));
    check("busy_vs_ss", 32'(bad), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    check("mosi_byte_count", 32'(mosi_q.size()), 32'd5);
    if (mosi_q.size() == 5) begin
      for (int k = 0; k < 5; k++)
        check("mosi_byte", 32'(mosi_q[k]), (k == 0) ? 32'(vecs[i].mosi0) : 32'd0);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int r, rel, dv_before;
    vecs[0] = '{40'h34_02_FF_03_05, 2'b00, 1'b0, 8'h80, 10'h234, 10'h3FF, 3'b101};
    vecs[1] = '{40'h12_01_AB_02_07, 2'b11, 1'b1, 8'h83, 10'h112, 10'h2AB, 3'b111};
    vecs[2] = '{40'h00_FE_00_FC_F8, 2'b00, 1'b0, 8'h80, 10'h200, 10'h000, 3'b000};
    vecs[3] = '{40'h55_03_66_01_02, 2'b10, 1'b0, 8'h82, 10'h355, 10'h166, 3'b010};
    vecs[4] = '{40'hC3_01_3C_02_01, 2'b01, 1'b0, 8'h81, 10'h1C3, 10'h23C, 3'b001};
    vecs[5] = '{40'hFF_FF_FF_FF_FF, 2'b00, 1'b0, 8'h80, 10'h3FF, 10'h3FF, 3'b111};
    vecs[6] = '{40'h00_00_00_00_00, 2'b00, 1'b0, 8'h80, 10'h000, 10'h000, 3'b000};
    vecs[7] = '{40'h80_02_01_01_04, 2'b11, 1'b0, 8'h83, 10'h280, 10'h101, 3'b100};
    vecs[8] = '{40'h7F_00_80_03_03, 2'b10, 1'b0, 8'h82, 10'h07F, 10'h380, 3'b011};

    rst     = 1'b0;
    led_cmd = 2'b00;
    repeat (3) @(negedge clk);
    rst = 1'b1;

    // Asynchronous reset at a random point inside the first transaction.
    r = $urandom_range(405, 560);
    repeat (r) @(posedge clk);
    #3;
    check("ss_low_before_rst", 32'(spi.ss), 32'd0);
    rst = 1'b0;
    #1;
    check_reset_outputs("rst_async");

    repeat (2) @(negedge clk);
    rst = 1'b1;
    rel = cyc;

    // Back-to-back table vectors: basic data, LED flip, upper-bit masking.
    run_txn(0, rel);
    run_txn(1, last_fall);
    run_txn(2, last_fall);

    // Reset during the third byte: nothing is published.
    slv_tx  = vecs[3].rx;
    led_cmd = vecs[3].led;
    mosi_q.delete();
    dv_before = dv_count;
    wait_ss_fall();
    check("mid_fall_cycle", 32'(cyc), 32'(last_fall + POLL_CYC));
    repeat (90) @(posedge clk);
    #2;
    check("ss_low_mid_byte3", 32'(spi.ss), 32'd0);
    rst = 1'b0;
    #1;
    check_reset_outputs("rst_mid");
    repeat (3) @(negedge clk);
    check("no_dv_after_abort", 32'(dv_count), 32'(dv_before));
    rst = 1'b1;
    rel = cyc;
    run_txn(3, rel);

    // Free run over five poll periods.
    dv_before = dv_count;
    for (int i = 4; i < 9; i++) run_txn(i, last_fall);
    check("free_run_dv_pulses", 32'(dv_count - dv_before), 32'd5);
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
